// File: rtl/alu_exec_stage.sv
// Execute/writeback stage around an external 16-bit ALU: reads an 8-entry register file,
// drives the ALU from registered operands and writes the result and C/Z/N flags back.
module alu_exec_stage #(
  parameter int unsigned N    = 16,
  parameter int unsigned REGS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_class,
  input  logic [2:0]   in_op,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs,
  input  logic [7:0]   in_imm,
  input  logic         in_use_imm,
  output logic [N-1:0] alu_operand1,
  output logic [N-1:0] alu_operand2,
  output logic         alu_carry_in,
  output logic         alu_enable_alu,
  output logic [2:0]   alu_alu_op,
  output logic         alu_enable_shift,
  output logic [2:0]   alu_shift_op,
  output logic         alu_enable_load,
  output logic [2:0]   alu_load_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry_out,
  output logic         wb_valid,
  output logic [2:0]   wb_rd,
  output logic [N-1:0] wb_data,
  output logic         flag_c,
  output logic         flag_z,
  output logic         flag_n,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);
  localparam int unsigned H = N / 2;
  localparam logic [1:0] ClsAlu   = 2'd0;
  localparam logic [1:0] ClsShift = 2'd1;
  localparam logic [1:0] ClsLoad  = 2'd2;
  localparam logic [1:0] ClsNop   = 2'd3;

  typedef enum logic [0:0] {StIdle, StExec} state_e;
  state_e r_state, w_state_next;

  logic [REGS-1:0][N-1:0] r_regs;
  logic [1:0]   r_class;
  logic [2:0]   r_op;
  logic [2:0]   r_rd;
  logic         r_nop;
  logic [N-1:0] r_operand1, r_operand2;
  logic         r_flag_c, r_flag_z, r_flag_n;
  logic         r_wb_valid;
  logic [2:0]   r_wb_rd;
  logic [N-1:0] r_wb_data;

  logic         w_accept;
  logic         w_nop;
  logic [H-1:0] w_imm_half;
  logic [N-1:0] w_op1, w_op2;

  assign w_accept   = (r_state == StIdle) && in_valid;
  assign w_nop      = (in_class == ClsNop) || ((in_class == ClsShift) && (in_op >= 3'd5));
  assign w_imm_half = H'(in_imm);

  // Byte-immediate loads merge {imm, imm} with R[rd] inside the ALU.
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    case (in_class)
      ClsAlu: begin
        w_op1 = r_regs[in_rd];
        w_op2 = in_use_imm ? N'(in_imm) : r_regs[in_rs];
      end
      ClsShift: w_op1 = r_regs[in_rs];
      ClsLoad: begin
        if (in_op[2]) begin
          w_op1 = {w_imm_half, w_imm_half};
          w_op2 = r_regs[in_rd];
        end else begin
          w_op1 = r_regs[in_rs];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (in_valid) w_state_next = StExec;
      StExec: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_regs     <= '0;
      r_class    <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_nop      <= 1'b0;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_flag_c   <= 1'b0;
      r_flag_z   <= 1'b0;
      r_flag_n   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wb_valid <= 1'b0;
      if (w_accept) begin
        r_class    <= in_class;
        r_op       <= in_op;
        r_rd       <= in_rd;
        r_nop      <= w_nop;
        r_operand1 <= w_op1;
        r_operand2 <= w_op2;
      end
      if ((r_state == StExec) && !r_nop) begin
        r_regs[r_rd] <= alu_result;
        r_flag_c     <= alu_carry_out;
        r_flag_z     <= (alu_result == '0);
        r_flag_n     <= alu_result[N-1];
        r_wb_valid   <= 1'b1;
        r_wb_rd      <= r_rd;
        r_wb_data    <= alu_result;
      end
    end
  end

  always_comb begin
    alu_enable_alu   = 1'b0;
    alu_enable_shift = 1'b0;
    alu_enable_load  = 1'b0;
    if ((r_state == StExec) && !r_nop) begin
      case (r_class)
        ClsAlu:   alu_enable_alu   = 1'b1;
        ClsShift: alu_enable_shift = 1'b1;
        ClsLoad:  alu_enable_load  = 1'b1;
        default:  ;
      endcase
    end
  end

  assign in_ready     = (r_state == StIdle);
  assign alu_operand1 = r_operand1;
  assign alu_operand2 = r_operand2;
  assign alu_carry_in = r_flag_c;
  assign alu_alu_op   = r_op;
  assign alu_shift_op = r_op;
  assign alu_load_op  = r_op;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign flag_c       = r_flag_c;
  assign flag_z       = r_flag_z;
  assign flag_n       = r_flag_n;
  assign dbg_data     = r_regs[dbg_addr];

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage wrapped around the 16-bit ALU.
- Accepts one decoded instruction per transaction over a valid/ready handshake.
- Reads an internal 8x16 register file and drives the ALU operand, carry and control ports from registered values.
- Writes the ALU result back to the register file and updates the C/Z/N flags. The carry flag feeds the ALU carry input.

Parameters:
N, 16, data width; must be even (byte split at N/2)
REGS, 8, register-file depth; register index width is 3 bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage can accept an instruction this cycle
in_class  input  2  0=alu, 1=shift, 2=load, 3=nop
in_op  input  3  operation code within class
in_rd  input  3  destination register (also first source for alu class)
in_rs  input  3  source register
in_imm  input  8  immediate byte
in_use_imm  input  1  alu class only: operand2 = zero-extended in_imm instead of R[rs]
alu_operand1  output  N  to ALU operand1
alu_operand2  output  N  to ALU operand2
alu_carry_in  output  1  to ALU carryIn (= flag C)
alu_enable_alu  output  1  ALU enable
alu_alu_op  output  3  ALU operation
alu_enable_shift  output  1  shift enable
alu_shift_op  output  3  shift operation
alu_enable_load  output  1  load enable
alu_load_op  output  3  load operation
alu_result  input  N  from ALU result
alu_carry_out  input  1  from ALU carryOut
wb_valid  output  1  one-cycle pulse: writeback performed
wb_rd  output  3  register written
wb_data  output  N  value written
flag_c  output  1  carry flag
flag_z  output  1  zero flag
flag_n  output  1  negative flag (result MSB)
dbg_addr  input  3  debug read address
dbg_data  output  N  combinational R[dbg_addr]

Behaviour:
- FSM states: IDLE, EXEC.
- IDLE:
  - in_ready=1.
  - If in_valid: latch class/op/rd, compute and register both operands, go to EXEC.
- EXEC:
  - in_ready=0. ALU control outputs are driven from the latched class/op.
  - At the clock edge: perform writeback, return to IDLE.
- Timing: accept at edge T, writeback at edge T+1. in_ready reasserts in the cycle after EXEC. Throughput is 1 instruction per 2 cycles. No hazards are possible.
- Operand selection (registered at accept):
  - alu class: op1=R[rd]; op2 = in_use_imm ? {0, imm} : R[rs].
  - shift class: op1=R[rs]; op2=0.
  - load class, op 0..3: op1=R[rs]; op2=0.
  - load class, op 4..7: op1={imm, imm}; op2=R[rd]. This yields LDLI={R[rd][N-1:N/2], imm}, LDHI={imm, R[rd][N/2-1:0]}, LDLZI={0, imm}, LDHZI={imm, 0}.
- Enables:
  - Exactly one of alu_enable_alu/alu_enable_shift/alu_enable_load is high in EXEC, per class.
  - All enables are 0 in IDLE and for NOPs.
  - Op fields are held at the latched op.
- NOP cases: class 3, or shift class with op 5..7. The stage still takes 2 cycles but performs no enables, no register write and no flag change, and wb_valid stays 0.
- Writeback at the EXEC edge:
  - R[rd] <= alu_result.
  - C <= alu_carry_out.
  - Z <= (alu_result==0).
  - N <= alu_result[N-1].
  - wb_valid=1 for exactly one cycle, with wb_rd=rd and wb_data=alu_result.
  - The ALU passes carryIn through for logic/load ops, so C is unchanged for those ops.
- in_valid is sampled only in IDLE. Inputs during EXEC are ignored, not queued.
- Reset:
  - All registers, flags, wb_valid and ALU outputs are cleared to 0; FSM goes to IDLE; in_ready=1 in the first cycle after reset.
  - Reset during EXEC abandons the instruction: no write, no wb_valid.
- dbg_data reflects a write from the cycle after the write edge.

Test Plan:
- Reset, then LDLZI rd=1 imm=0x34; then LDHI rd=1 imm=0x12 -> R1=0x1234, wb_valid pulses twice 2 cycles apart, Z=0, N=0.
- R1=0xFFFF, ADD rd=1 imm=0x01 use_imm -> R1=0x0000, C=1, Z=1, N=0; next ADC rd=2 (R2=0) rs=2 -> R2=0x0001, C=0.
- R3=0x8001, ASHR rd=4 rs=3 -> R4=0xC000, C=1, N=1; then ROR rd=5 rs=5 (R5=0) -> R5=0x8000, C=0.
- in_valid held high continuously for 3 instructions -> in_ready toggles 1,0; one writeback every 2 cycles; no instruction dropped or duplicated.
- class=3 and shift op=6 -> no enables asserted, registers and flags unchanged, wb_valid=0, in_ready back after 2 cycles.
- Accept SUB rd=6, then assert reset in EXEC -> R6=0, flags 0, wb_valid=0, in_ready=1 the cycle after reset deasserts.
